hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide engine that sits beside the EX stage and writes the hi/lo register pair.
- Handles MULT, MULTU, DIV and DIVU over a parametrised operand width using radix-2 shift-add and shift-subtract.
- Holds the pipeline through a busy/done handshake. The hazard unit stalls IF/ID and bubbles ID/EX while busy is high.
- Accepts a cancel from branch/flush control.

Parameters:
- DATA_WIDTH, 32: operand width and hi/lo width in bits. Must be at least 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: width of the iteration counter.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation. Sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  in  DATA_WIDTH  rs operand: multiplicand or dividend.
- src_b  in  DATA_WIDTH  rt operand: multiplier or divisor.
- cancel  in  1  abort the operation in flight; no result is produced.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse in DONE; hi_out/lo_out are valid.
- hi_out  out  DATA_WIDTH  product upper half, or remainder.
- lo_out  out  DATA_WIDTH  product lower half, or quotient.
- we_hi  out  1  equals done.
- we_lo  out  1  equals done.
- div_by_zero  out  1  pulse alongside done when a DIV/DIVU has src_b == 0.

Behaviour:
- Reset values: state IDLE; busy, done, we_hi, we_lo, div_by_zero = 0; hi_out, lo_out = 0; counter = 0. Reset overrides every other input, including in the middle of an operation.
- IDLE:
  - If start=1 and cancel=0, latch op, the operand magnitudes and the sign flags; counter=DATA_WIDTH; go to CALC.
  - Signed ops (op[0]=1) take two's-complement magnitudes. For -2^(W-1) the magnitude is 2^(W-1), which is representable unsigned.
- CALC, one iteration per cycle:
  - Multiply: if multiplier LSB is 1, add multiplicand to the upper accumulator (W+1 bits, carry kept); shift the 2W accumulator right by 1.
  - Divide (restoring): shift {rem,quot} left by 1; if rem >= divisor, subtract and set quot LSB.
  - Counter decrements; the transition to FIX happens when the counter reaches 1.
- FIX, one cycle:
  - Signed multiply: negate the 2W product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Divide by zero, any signedness: hi = src_a as latched, lo = all ones, div_by_zero = 1. Divide by zero does not shorten the latency.
  - Load hi_out/lo_out; go to DONE.
- DONE, one cycle: done = we_hi = we_lo = 1; go to IDLE. hi_out/lo_out hold until the next FIX.
- Latency: start is accepted at edge N; busy is high for cycles N+1 .. N+DATA_WIDTH+1; done is high in cycle N+DATA_WIDTH+2.
- Overflow wrap: MIN/-1 signed gives quotient MIN and remainder 0, with no exception.
- start while busy or in DONE is ignored; no queueing.
- cancel in CALC/FIX: go to IDLE next cycle; no done; hi_out/lo_out unchanged.
- cancel in DONE: the pulse completes. The write is not retracted; flush logic must cancel before FIX.
- start and cancel together in IDLE: cancel wins and nothing starts.

Optional Feature:
- Macro: HILO_MULDIV_FAST_MUL_EN.
- When defined:
  - MULT/MULTU skip CALC and compute a full-width product with the native multiplier in one cycle, registered into FIX.
  - Multiply then gives done at N+3 and busy at N+1..N+2.
  - Divide timing is unchanged.
- When undefined: all four ops use the iterative path, and no multiplier primitive is inferred.

Decomposition:
- Shared definitions package (define file):
  - MulDivOpWidth = 2
  - the op encodings MD_MULTU, MD_MULT, MD_DIVU, MD_DIV
  - state encodings MD_IDLE, MD_CALC, MD_FIX, MD_DONE
- One natural sub-module: hilo_muldiv_step. It is combinational, computes one shift-add or shift-subtract iteration, and is instantiated once.

Test Plan:
- MULTU 7 x 6, W=32 -> done exactly 34 cycles after start; hi=0x00000000, lo=0x0000002A; busy high for 33 cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF; div_by_zero pulses together with done.
- Start DIVU, assert cancel at cycle 10 -> idle next cycle, no done. Then start MULTU 2 x 3, with start asserted during busy ignored -> lo=6 only.
- rst in the middle of CALC -> all outputs 0 the next cycle. A start in the same cycle as rst is ignored.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op and state encodings shared by the hi/lo multiply/divide unit.
package hilo_muldiv_pkg;
  localparam int MulDivOpWidth = 2;
  typedef enum logic [MulDivOpWidth-1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;
endpackage

// File: rtl/hilo_muldiv_step.sv
// hilo_muldiv_step: one radix-2 iteration, shift-add for multiply or restoring shift-subtract for divide.
module hilo_muldiv_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [2*W:0] acc,
  input  logic [W-1:0] opnd,
  output logic [2*W:0] acc_next
);
  logic [W:0] upper, sum, rem, diff;
  logic [2*W:0] sh;
  logic ge;
  always_comb begin
    upper = acc[2*W:W];
    sum = acc[0] ? upper + {1'b0, opnd} : upper;
    sh = {acc[2*W-1:0], 1'b0};
    rem = sh[2*W:W];
    diff = rem - {1'b0, opnd};
    ge = rem >= {1'b0, opnd};
    acc_next = is_div ? (ge ? {diff, sh[W-1:0]} | (2*W+1)'(1) : sh) : {1'b0, sum, acc[W-1:1]};
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine writing hi/lo with a busy/done handshake.
// Define HILO_MULDIV_FAST_MUL_EN to compute multiplies with the native multiplier in a single cycle.
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MulDivOpWidth-1:0] op,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  input  logic                     cancel,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    hi_out,
  output logic [DATA_WIDTH-1:0]    lo_out,
  output logic                     we_hi,
  output logic                     we_lo,
  output logic                     div_by_zero
);
  localparam int W = DATA_WIDTH;
  md_state_e state, state_n;
  logic go, is_div_in, signed_in, is_div, sign_a, sign_b, dbz_q;
  logic [W-1:0] a_mag, b_mag, opnd, quot, rem, hi_n, lo_n;
  logic [2*W:0] acc, acc_step, acc_calc;
  logic [2*W-1:0] prod;
  logic [CNT_WIDTH-1:0] cnt, cnt_init;
  assign go = start && !cancel;
  assign is_div_in = op == MD_DIVU || op == MD_DIV;
  assign signed_in = op == MD_MULT || op == MD_DIV;
  assign a_mag = signed_in && src_a[W-1] ? -src_a : src_a;
  assign b_mag = signed_in && src_b[W-1] ? -src_b : src_b;
  hilo_muldiv_step #(.W(W)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_next(acc_step)
  );
`ifdef HILO_MULDIV_FAST_MUL_EN
  assign cnt_init = is_div_in ? CNT_WIDTH'(W) : CNT_WIDTH'(1);
  assign acc_calc = is_div ? acc_step : {1'b0, (2*W)'(opnd) * (2*W)'(acc[W-1:0])};
`else
  assign cnt_init = CNT_WIDTH'(W);
  assign acc_calc = acc_step;
`endif
  // Divide by zero leaves {dividend magnitude, all ones} in acc, so the remainder path rebuilds src_a.
  assign prod = (sign_a ^ sign_b) ? -acc[2*W-1:0] : acc[2*W-1:0];
  assign quot = acc[W-1:0];
  assign rem = acc[2*W-1:W];
  assign hi_n = is_div ? (sign_a ? -rem : rem) : prod[2*W-1:W];
  assign lo_n = !is_div ? prod[W-1:0] : opnd == '0 ? '1 : (sign_a ^ sign_b) ? -quot : quot;
  always_ff @(posedge clk)
    if (rst) state <= MD_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      MD_IDLE: state_n = go ? MD_CALC : MD_IDLE;
      MD_CALC: begin
        busy = 1'b1;
        state_n = cancel ? MD_IDLE : cnt == CNT_WIDTH'(1) ? MD_FIX : MD_CALC;
      end
      MD_FIX: begin
        busy = 1'b1;
        state_n = cancel ? MD_IDLE : MD_DONE;
      end
      default: begin
        done = 1'b1;
        state_n = MD_IDLE;
      end
    endcase
  end
  assign we_hi = done;
  assign we_lo = done;
  assign div_by_zero = done && dbz_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dbz_q <= 1'b0;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        MD_IDLE: if (go) begin
          is_div <= is_div_in;
          sign_a <= signed_in && src_a[W-1];
          sign_b <= signed_in && src_b[W-1];
          opnd <= is_div_in ? b_mag : a_mag;
          acc <= {{(W+1){1'b0}}, is_div_in ? a_mag : b_mag};
          cnt <= cnt_init;
        end
        MD_CALC: if (!cancel) begin
          acc <= acc_calc;
          cnt <= cnt - CNT_WIDTH'(1);
        end
        MD_FIX: if (!cancel) begin
          hi_out <= hi_n;
          lo_out <= lo_n;
          dbz_q <= is_div && opnd == '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors with hand-computed results for the hi/lo multiply/divide unit.
module tb_hilo_muldiv_unit;
`ifdef HILO_MULDIV_FAST_MUL_EN
  localparam int MLAT = 3, MBUSY = 2;
`else
  localparam int MLAT = 34, MBUSY = 33;
`endif
  localparam int DLAT = 34, DBUSY = 33;
  logic clk, rst, start, cancel, busy, done, we_hi, we_lo, div_by_zero;
  logic [1:0] op;
  logic [31:0] src_a, src_b, hi_out, lo_out;
  int checks, errors, dcnt;
  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .we_hi(we_hi), .we_lo(we_lo), .div_by_zero(div_by_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int elat, input int ebusy, input int poke, input logic dpoke);
    int cyc, bcnt;
    logic seen;
    cyc = 0;
    bcnt = 0;
    seen = 1'b0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (busy) bcnt++;
        if (cyc == poke) begin
          start = 1'b1; src_a = 32'd9; src_b = 32'd9;
        end
        @(posedge clk);
        cyc++;
        #1 start = 1'b0;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, cyc, elat);
    chk({tag, "_busy"}, bcnt, ebusy);
    chk({tag, "_hi"}, hi_out, eh);
    chk({tag, "_lo"}, lo_out, el);
    chk({tag, "_we"}, {30'd0, we_hi, we_lo}, 32'd3);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ed));
    if (dpoke) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "_hold"}, hi_out ^ lo_out, eh ^ el);
  endtask
  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {26'd0, busy, done, we_hi, we_lo, div_by_zero, 1'b0}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    rst = 1'b0;
    run_op("multu_7x6", 2'b00, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, MLAT, MBUSY, 0, 1'b0);
    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MLAT, MBUSY, 0, 1'b0);
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, MLAT, MBUSY, 0, 1'b0);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DLAT, DBUSY, 0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, DLAT, DBUSY, 0, 1'b0);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DLAT, DBUSY, 0, 1'b0);
    run_op("divu_dbz", 2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, DLAT, DBUSY, 0, 1'b0);
    run_op("div_dbz", 2'b11, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, DLAT, DBUSY, 0, 1'b0);
    // cancel in the tenth cycle of a divide
    @(negedge clk);
    op = 2'b10; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle", 32'(busy), 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("cancel_nodone", dcnt, 0);
    chk("cancel_hi", hi_out, 32'hFFFF_FFF9);
    chk("cancel_lo", lo_out, 32'hFFFF_FFFF);
    run_op("multu_2x3_poke", 2'b00, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, MLAT, MBUSY, 5, 1'b1);
    // reset mid-operation with a simultaneous start
    @(negedge clk);
    op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("midrst_ctl", {26'd0, busy, done, we_hi, we_lo, div_by_zero, 1'b0}, 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    @(negedge clk);
    chk("midrst_nostart", 32'(busy), 32'd0);
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, MLAT, MBUSY, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
